hazard_sched: RTL and testbench

Pipeline hazard scheduler for the 5-stage core. It keeps a shadow copy of the destination-register state of the EXE, MEM and WB stages and decides each cycle whether the instruction in ID may issue. It drives the ID-stage stall, inserts bubbles on stall or branch flush, honours a memory freeze, and optionally selects forwarding paths. It sits beside the ID/EXE pipeline register and replaces the purely combinational hazard check.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_slot_cmp.sv | 22 ++
 rtl/hazard_sched.sv | 108 ++++++++++
 tb/tb_hazard_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard scheduler.
package hazard_pkg;

    localparam int REG_IDX_W = 5;

    localparam int STG_EXE   = 0;
    localparam int STG_MEM   = 1;
    localparam int STG_WB    = 2;
    localparam int NUM_SLOTS = 3;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dest;
        logic                 wb_en;
        logic                 is_load;
    } slot_t;

endpackage

// File: rtl/hazard_slot_cmp.sv
// Compares one shadow slot against the ID-stage source registers.
module hazard_slot_cmp
    import hazard_pkg::*;
#(
    parameter int NREG_W = REG_IDX_W
) (
    input  slot_t             slot_i,
    input  logic [NREG_W-1:0] src1_i,
    input  logic [NREG_W-1:0] src2_i,
    input  logic              use_src2_i,
    output logic              match1_o,
    output logic              match2_o
);

    logic live;

    // r0 is hardwired to zero, so a write to it never creates a dependency
    assign live     = slot_i.valid & slot_i.wb_en & (slot_i.dest != '0);
    assign match1_o = live & (src1_i == slot_i.dest);
    assign match2_o = live & use_src2_i & (src2_i == slot_i.dest);

endmodule

// File: rtl/hazard_sched.sv
// ID-stage hazard scheduler with EXE/MEM/WB shadow slots.
// Build option: define FORWARDING_EN to enable operand forwarding (load-use stalls only).
module hazard_sched
    import hazard_pkg::*;
#(
    parameter int NREG_W = REG_IDX_W,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [NREG_W-1:0] id_src1,
    input  logic [NREG_W-1:0] id_src2,
    input  logic              id_use_src2,
    input  logic [NREG_W-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              freeze,
    output logic              stall,
    output logic              issue,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [PERF_W-1:0] stall_cnt
);

    slot_t              slot_q [NUM_SLOTS];
    slot_t              slot_d [NUM_SLOTS];
    slot_t              id_slot;
    logic [NUM_SLOTS-1:0] m1;
    logic [NUM_SLOTS-1:0] m2;
    logic               slot_hit;
    logic               hazard;
    logic [PERF_W-1:0]  stall_cnt_q;
    logic [PERF_W-1:0]  stall_cnt_d;
    logic               unused_wb;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_cmp
        hazard_slot_cmp #(.NREG_W(NREG_W)) u_cmp (
            .slot_i     (slot_q[g]),
            .src1_i     (id_src1),
            .src2_i     (id_src2),
            .use_src2_i (id_use_src2),
            .match1_o   (m1[g]),
            .match2_o   (m2[g])
        );
    end

    // The WB slot is tracked for completeness but never stalls: the regfile writes before the read
    assign unused_wb = ^{m1[STG_WB], m2[STG_WB], slot_q[STG_WB]};

`ifdef FORWARDING_EN
    assign slot_hit = (m1[STG_EXE] | m2[STG_EXE]) & slot_q[STG_EXE].is_load;
`else
    assign slot_hit = m1[STG_EXE] | m2[STG_EXE] | m1[STG_MEM] | m2[STG_MEM];
`endif

    assign hazard = id_valid & slot_hit;
    assign stall  = ~rst & (freeze | (hazard & ~flush));
    assign issue  = ~rst & id_valid & ~stall & ~flush;

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
`ifdef FORWARDING_EN
        if (!rst) begin
            if (m1[STG_EXE] & ~slot_q[STG_EXE].is_load) fwd_a = FWD_EXE;
            else if (m1[STG_MEM])                         fwd_a = FWD_MEM;
            if (m2[STG_EXE] & ~slot_q[STG_EXE].is_load) fwd_b = FWD_EXE;
            else if (m2[STG_MEM])                         fwd_b = FWD_MEM;
        end
`endif
    end

    always_comb begin
        id_slot         = '0;
        id_slot.valid   = 1'b1;
        id_slot.dest    = id_dest;
        id_slot.wb_en   = id_wb_en;
        id_slot.is_load = id_is_load;
        slot_d = slot_q;
        if (!freeze) begin
            slot_d[STG_WB]  = slot_q[STG_MEM];
            slot_d[STG_MEM] = slot_q[STG_EXE];
            slot_d[STG_EXE] = issue ? id_slot : '0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard & ~freeze & ~flush & ~(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '{default: '0};
            stall_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed self-checking bench for hazard_sched; expectations follow the FORWARDING_EN build option.
module tb_hazard_sched;

    localparam int NREG_W = 5;
    localparam int PERF_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [NREG_W-1:0] id_src1;
    logic [NREG_W-1:0] id_src2;
    logic              id_use_src2;
    logic [NREG_W-1:0] id_dest;
    logic              id_wb_en;
    logic              id_is_load;
    logic              flush;
    logic              freeze;
    logic              stall;
    logic              issue;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [PERF_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_sched #(.NREG_W(NREG_W), .PERF_W(PERF_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_use_src2 (id_use_src2),
        .id_dest     (id_dest),
        .id_wb_en    (id_wb_en),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .freeze      (freeze),
        .stall       (stall),
        .issue       (issue),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                          input logic u2, input logic [4:0] d, input logic wb, input logic ld);
        id_valid = v; id_src1 = s1; id_src2 = s2; id_use_src2 = u2;
        id_dest = d; id_wb_en = wb; id_is_load = ld;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        flush = 1'b0;
        freeze = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1);
        freeze = 1'b1; flush = 1'b0;
        tick();
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", stall); end
        n_cmp++; if (issue !== 1'b0) begin n_bad++; $display("FAIL reset_issue got %0b want 0", issue); end
        n_cmp++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin n_bad++; $display("FAIL reset_fwd got %0d/%0d want 0/0", fwd_a, fwd_b); end
        n_cmp++; if (stall_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
        rst = 1'b0; freeze = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0 || issue !== 1'b1) begin n_bad++; $display("FAIL post_reset got stall=%0b issue=%0b want 0/1", stall, issue); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
        #1;
        n_cmp++; if (issue !== 1'b1) begin n_bad++; $display("FAIL lu_load_issue got %0b want 1", issue); end
        tick();
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        n_cmp++; if (stall !== 1'b1 || issue !== 1'b0) begin n_bad++; $display("FAIL lu_t1 got stall=%0b issue=%0b want 1/0", stall, issue); end
        tick();
`ifdef FORWARDING_EN
        n_cmp++; if (stall !== 1'b0 || issue !== 1'b1) begin n_bad++; $display("FAIL lu_t2 got stall=%0b issue=%0b want 0/1", stall, issue); end
        n_cmp++; if (fwd_a !== 2'd2) begin n_bad++; $display("FAIL lu_fwd_a got %0d want 2", fwd_a); end
        tick(); idle(); #1;
        n_cmp++; if (stall_cnt !== 3'd1) begin n_bad++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
`else
        n_cmp++; if (stall !== 1'b1 || issue !== 1'b0) begin n_bad++; $display("FAIL lu_t2 got stall=%0b issue=%0b want 1/0", stall, issue); end
        tick();
        n_cmp++; if (stall !== 1'b0 || issue !== 1'b1) begin n_bad++; $display("FAIL lu_t3 got stall=%0b issue=%0b want 0/1", stall, issue); end
        n_cmp++; if (fwd_a !== 2'd0) begin n_bad++; $display("FAIL lu_fwd_a got %0d want 0", fwd_a); end
        tick(); idle(); #1;
        n_cmp++; if (stall_cnt !== 3'd2) begin n_bad++; $display("FAIL lu_cnt got %0d want 2", stall_cnt); end
`endif
    endtask

    task automatic test_alu_dep();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
`ifdef FORWARDING_EN
        n_cmp++; if (stall !== 1'b0 || issue !== 1'b1) begin n_bad++; $display("FAIL alu_t1 got stall=%0b issue=%0b want 0/1", stall, issue); end
        n_cmp++; if (fwd_a !== 2'd0 || fwd_b !== 2'd1) begin n_bad++; $display("FAIL alu_fwd got %0d/%0d want 0/1", fwd_a, fwd_b); end
        tick();
        // r3 now in MEM; immediate form must not forward on src2
        set_id(1'b1, 5'd3, 5'd3, 1'b0, 5'd5, 1'b1, 1'b0);
        #1;
        n_cmp++; if (fwd_a !== 2'd2 || fwd_b !== 2'd0) begin n_bad++; $display("FAIL alu_mem_fwd got %0d/%0d want 2/0", fwd_a, fwd_b); end
        tick(); idle(); #1;
        n_cmp++; if (stall_cnt !== 3'd0) begin n_bad++; $display("FAIL alu_cnt got %0d want 0", stall_cnt); end
`else
        n_cmp++; if (stall !== 1'b1 || issue !== 1'b0) begin n_bad++; $display("FAIL alu_t1 got stall=%0b issue=%0b want 1/0", stall, issue); end
        tick();
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL alu_t2 got stall=%0b want 1", stall); end
        tick();
        n_cmp++; if (stall !== 1'b0 || issue !== 1'b1) begin n_bad++; $display("FAIL alu_t3 got stall=%0b issue=%0b want 0/1", stall, issue); end
        n_cmp++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin n_bad++; $display("FAIL alu_fwd got %0d/%0d want 0/0", fwd_a, fwd_b); end
        tick(); idle(); #1;
        n_cmp++; if (stall_cnt !== 3'd2) begin n_bad++; $display("FAIL alu_cnt got %0d want 2", stall_cnt); end
`endif
    endtask

    task automatic test_r0();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
        #1;
        n_cmp++; if (stall !== 1'b0 || issue !== 1'b1) begin n_bad++; $display("FAIL r0_issue got stall=%0b issue=%0b want 0/1", stall, issue); end
        n_cmp++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin n_bad++; $display("FAIL r0_fwd got %0d/%0d want 0/0", fwd_a, fwd_b); end
        tick(); idle();
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0 || issue !== 1'b0) begin n_bad++; $display("FAIL flush_out got stall=%0b issue=%0b want 0/0", stall, issue); end
        tick();
        flush = 1'b0;
        #1;
        n_cmp++; if (stall_cnt !== 3'd0) begin n_bad++; $display("FAIL flush_cnt got %0d want 0", stall_cnt); end
`ifdef FORWARDING_EN
        n_cmp++; if (stall !== 1'b0 || issue !== 1'b1 || fwd_a !== 2'd2) begin n_bad++; $display("FAIL flush_bubble got stall=%0b issue=%0b fwd_a=%0d want 0/1/2", stall, issue, fwd_a); end
`else
        n_cmp++; if (stall !== 1'b1 || issue !== 1'b0) begin n_bad++; $display("FAIL flush_bubble got stall=%0b issue=%0b want 1/0", stall, issue); end
        tick();
        n_cmp++; if (stall !== 1'b0 || issue !== 1'b1) begin n_bad++; $display("FAIL flush_after got stall=%0b issue=%0b want 0/1", stall, issue); end
`endif
        tick(); idle();
    endtask

    task automatic test_freeze();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (stall !== 1'b1 || issue !== 1'b0) begin n_bad++; $display("FAIL frz_hold%0d got stall=%0b issue=%0b want 1/0", i, stall, issue); end
            tick();
        end
        freeze = 1'b0;
        #1;
        n_cmp++; if (stall_cnt !== 3'd0) begin n_bad++; $display("FAIL frz_cnt got %0d want 0", stall_cnt); end
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL frz_release got stall=%0b want 1", stall); end
        tick();
`ifdef FORWARDING_EN
        n_cmp++; if (issue !== 1'b1 || fwd_a !== 2'd2 || stall_cnt !== 3'd1) begin n_bad++; $display("FAIL frz_issue got issue=%0b fwd_a=%0d cnt=%0d want 1/2/1", issue, fwd_a, stall_cnt); end
`else
        n_cmp++; if (stall !== 1'b1 || stall_cnt !== 3'd1) begin n_bad++; $display("FAIL frz_t2 got stall=%0b cnt=%0d want 1/1", stall, stall_cnt); end
        tick();
        n_cmp++; if (issue !== 1'b1 || stall_cnt !== 3'd2) begin n_bad++; $display("FAIL frz_issue got issue=%0b cnt=%0d want 1/2", issue, stall_cnt); end
`endif
        tick(); idle();
    endtask

    task automatic test_rst_mid();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rstm_pre got stall=%0b want 1", stall); end
        rst = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0 || issue !== 1'b0 || fwd_a !== 2'd0) begin n_bad++; $display("FAIL rstm_during got stall=%0b issue=%0b fwd_a=%0d want 0/0/0", stall, issue, fwd_a); end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0 || issue !== 1'b1 || fwd_a !== 2'd0 || stall_cnt !== 3'd0) begin n_bad++; $display("FAIL rstm_after got stall=%0b issue=%0b fwd_a=%0d cnt=%0d want 0/1/0/0", stall, issue, fwd_a, stall_cnt); end
        tick(); idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_id(1'b1, 5'(10 + i), 5'(15 + i), 1'b1, 5'(20 + i), 1'b1, 1'b0);
            #1;
            n_cmp++; if (stall !== 1'b0 || issue !== 1'b1) begin n_bad++; $display("FAIL b2b_%0d got stall=%0b issue=%0b want 0/1", i, stall, issue); end
            tick();
        end
        idle();
    endtask

    task automatic test_saturate();
        bit issued;
        do_reset();
        for (int p = 0; p < 9; p++) begin
            set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
            issued = 1'b0;
            for (int k = 0; k < 4; k++) begin
                #1;
                if (issue) begin
                    issued = 1'b1;
                    break;
                end
                tick();
            end
            n_cmp++; if (!issued) begin n_bad++; $display("FAIL sat_issue_%0d got no issue within 4 cycles want issue", p); end
            tick();
            if (p == 6) begin
                idle(); #1;
                n_cmp++; if (stall_cnt !== 3'd7) begin n_bad++; $display("FAIL sat_reach got %0d want 7", stall_cnt); end
            end
        end
        idle(); #1;
        n_cmp++; if (stall_cnt !== 3'd7) begin n_bad++; $display("FAIL sat_nowrap got %0d want 7", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_dep();
        test_r0();
        test_flush();
        test_freeze();
        test_rst_mid();
        test_back_to_back();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
